// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - byte/half/word load-store front end for the data BSRAM (optional macro DMEM_MISALIGN_TRAP_EN)
module dmem_access_unit #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_readEnable,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic                  mem_writeEnable,
  output logic [ADDR_WIDTH-1:0] mem_writeAddress,
  output logic [DATA_WIDTH-1:0] mem_writeData
);

  // The lane logic below is hard-wired for 4 byte lanes; the core index is a debug tag only.
  if (DATA_WIDTH != 32 || CORE < 0) begin : g_param_check
    $error("dmem_access_unit: only DATA_WIDTH=32 with a non-negative CORE is supported");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            lane;
  logic                  is_word;
  logic                  is_half;
  logic                  misaligned;
  logic                  accept;
  logic                  go;
  logic                  sub_store;

  // Read-modify-write context held across the WRITE cycle.
  logic [ADDR_WIDTH-1:0] rmw_addr_q;
  logic [31:0]           rmw_old_q;
  logic [1:0]            rmw_lane_q;
  logic                  rmw_half_q;
  logic [15:0]           rmw_wdata_q;

  logic [31:0] merged;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word_addr = req_address[ADDR_WIDTH+1:2];
  assign lane      = req_address[1:0];
  // Size 11 falls into the word path when it is not trapped.
  assign is_word   = req_size[1];
  assign is_half   = (req_size == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (is_half & lane[0])
                    | ((req_size == 2'b10) & (lane != 2'b00))
                    | (req_size == 2'b11);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready = reset & (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign go        = accept & ~misaligned;
  assign sub_store = go & req_write & ~is_word;

  // Pick the addressed lane out of the same-cycle read word and extend it.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = lane[1] ? mem_readData[31:16] : mem_readData[15:0];
    load_data = mem_readData;
    case (lane)
      2'd0:    byte_sel = mem_readData[7:0];
      2'd1:    byte_sel = mem_readData[15:8];
      2'd2:    byte_sel = mem_readData[23:16];
      default: byte_sel = mem_readData[31:24];
    endcase
    if (!is_word) begin
      if (is_half) begin
        load_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      end else begin
        load_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      end
    end
  end

  // Overlay the registered store bytes onto the registered old word.
  always_comb begin
    merged = rmw_old_q;
    if (rmw_half_q) begin
      if (rmw_lane_q[1]) begin
        merged[31:16] = rmw_wdata_q;
      end else begin
        merged[15:0] = rmw_wdata_q;
      end
    end else begin
      merged[8*rmw_lane_q +: 8] = rmw_wdata_q[7:0];
    end
  end

  // Next-state and BSRAM port control; all enables forced off while reset is low.
  always_comb begin
    state_d          = state_q;
    mem_readEnable   = 1'b0;
    mem_writeEnable  = 1'b0;
    mem_readAddress  = word_addr;
    mem_writeAddress = word_addr;
    mem_writeData    = req_wdata;
    case (state_q)
      IDLE: begin
        if (go) begin
          mem_readEnable  = ~req_write | ~is_word;
          mem_writeEnable = req_write & is_word;
          if (sub_store) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_writeEnable  = 1'b1;
        mem_writeAddress = rmw_addr_q;
        mem_writeData    = merged;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      mem_readEnable  = 1'b0;
      mem_writeEnable = 1'b0;
    end
  end

  // State register and response pulse; sub-word stores respond from the WRITE cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= (accept & ~sub_store) | (state_q == WRITE);
      resp_rdata <= (go & ~req_write) ? load_data : '0;
    end
  end

  // Capture the read-modify-write context when a sub-word store is accepted.
  always_ff @(posedge clock) begin
    if (sub_store) begin
      rmw_addr_q  <= word_addr;
      rmw_old_q   <= mem_readData;
      rmw_lane_q  <= lane;
      rmw_half_q  <= is_half;
      rmw_wdata_q <= req_wdata[15:0];
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  // Rejected requests report at T+1 alongside resp_valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept & misaligned;
    end
  end

  assign resp_misaligned = mis_q;
`else
  assign resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit against a byte-array reference
module tb_dmem_access_unit;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_address = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          mem_readEnable;
  logic [AW-1:0] mem_readAddress;
  logic [31:0]   mem_readData;
  logic          mem_writeEnable;
  logic [AW-1:0] mem_writeAddress;
  logic [31:0]   mem_writeData;

  always #5 clock = ~clock;

  dmem_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
    .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
    .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData)
  );

  // BSRAM stand-in: combinational read, write on the rising edge.
  logic [31:0]   bsram [0:(1<<AW)-1];
  int            wr_count = 0;
  logic [AW-1:0] last_wr_addr = '0;
  assign mem_readData = bsram[mem_readAddress];
  always @(posedge clock) begin
    if (mem_writeEnable) begin
      bsram[mem_writeAddress] <= mem_writeData;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_writeAddress;
    end
  end

  // Reference memory as individual bytes, little-endian.
  logic [7:0] ref_mem [0:(4<<AW)-1];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_exec(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [AW+1:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis);
    int nb;
    int start;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    start = int'(a) - (int'(a) % nb);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (sz == 2'd3) || ((int'(a) % nb) != 0);
`else
    mis = 1'b0;
`endif
    rd = 32'h0;
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[start + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[start + i];
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
    logic [31:0] exp;
    logic mis;
    int wr0;
    ref_exec(w, sz, uns, a, wd, exp, mis);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_address = a; req_wdata = wd;
    #1;
    check("req_ready_at_T", req_ready, 1);
    wr0 = wr_count;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    if (w && !mis && !sz[1]) begin
      check("rmw_ready_T1", req_ready, 0);
      check("rmw_valid_T1", resp_valid, 0);
      @(negedge clock);
      check("rmw_ready_T2", req_ready, 1);
    end
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, exp);
    check("resp_misaligned", resp_misaligned, mis);
    check("write_count", wr_count - wr0, (w && !mis) ? 1 : 0);
    rd = resp_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    int wr0;
    for (int i = 0; i < (1 << AW); i++) bsram[i] = 32'h0;
    for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h00;

    // Reset held low for two cycles.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("rst_ready", req_ready, 0);
      check("rst_rd_en", mem_readEnable, 0);
      check("rst_wr_en", mem_writeEnable, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
    end
    reset = 1'b1;
    #1;
    check("ready_after_release", req_ready, 1);

    // Word store then word load, back to back.
    issue(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF, rd);
    issue(1'b0, 2'd2, 1'b0, 'h10, 32'h0, rd);
    check("word_load", rd, 32'hDEADBEEF);

    // Byte store then signed byte load and word load.
    issue(1'b1, 2'd0, 1'b0, 'h11, 32'h00000080, rd);
    issue(1'b0, 2'd0, 1'b0, 'h11, 32'h0, rd);
    check("byte_load_signed", rd, 32'hFFFFFF80);
    issue(1'b0, 2'd2, 1'b0, 'h10, 32'h0, rd);
    check("word_after_byte", rd, 32'hDEAD80EF);

    // Half loads of the upper lane.
    issue(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF, rd);
    issue(1'b0, 2'd1, 1'b1, 'h12, 32'h0, rd);
    check("half_unsigned", rd, 32'h0000DEAD);
    issue(1'b0, 2'd1, 1'b0, 'h12, 32'h0, rd);
    check("half_signed", rd, 32'hFFFFDEAD);

    // Reset during the WRITE cycle of a byte store drops the write.
    issue(1'b1, 2'd2, 1'b0, 'h14, 32'h12345678, rd);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_address = 'h15; req_wdata = 32'h000000AA;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("write_cycle_wr_en", mem_writeEnable, 1);
    wr0 = wr_count;
    reset = 1'b0;
    #1;
    check("rst_in_write_wr_en", mem_writeEnable, 0);
    check("rst_in_write_ready", req_ready, 0);
    @(negedge clock);
    check("rst_in_write_valid", resp_valid, 0);
    check("rst_in_write_count", wr_count - wr0, 0);
    reset = 1'b1;
    #1;
    check("rst_in_write_idle", req_ready, 1);
    @(negedge clock);
    check("rst_in_write_no_resp", resp_valid, 0);
    issue(1'b0, 2'd2, 1'b0, 'h14, 32'h0, rd);
    check("rst_in_write_word", rd, 32'h12345678);

    // Misaligned word store.
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(1'b1, 2'd2, 1'b0, 'h13, 32'hCAFEF00D, rd);
    check("trap_rdata", rd, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 'h10, 32'h0, rd);
    check("trap_word_kept", rd, 32'hDEADBEEF);
`else
    issue(1'b1, 2'd2, 1'b0, 'h13, 32'hCAFEF00D, rd);
    check("misalign_wr_addr", last_wr_addr, 32'h4);
    issue(1'b0, 2'd2, 1'b0, 'h10, 32'h0, rd);
    check("misalign_word", rd, 32'hCAFEF00D);
`endif

    // Randomized mix over a small window so loads hit earlier stores.
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            (AW+2)'($urandom_range(0, 63)), $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store front end for the word-wide data BSRAM. It accepts byte, halfword and word requests from the pipeline's memory stage and drives the BSRAM read/write ports directly. For loads it extracts the addressed lane and sign- or zero-extends it. Sub-word stores become a registered two-cycle read-modify-write, so the read-to-merge-to-write path never closes in one cycle.

## Interface
Parameters:
- CORE, 0, core index (debug only)
- DATA_WIDTH, 32, word width; only 32 is supported
- ADDR_WIDTH, 8, BSRAM word-address width; byte address is ADDR_WIDTH+2 bits

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1
- req_address  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_misaligned  out  1  request rejected (see Configuration)
- mem_readEnable / mem_readAddress  out  1 / ADDR_WIDTH  BSRAM read port
- mem_readData  in  32  BSRAM same-cycle read data
- mem_writeEnable / mem_writeAddress / mem_writeData  out  1 / ADDR_WIDTH / 32  BSRAM write port

## Operation
- Request accepted on cycle T when req_valid & req_ready.
- Word address = req_address[ADDR_WIDTH+1:2]. Lane = req_address[1:0].
- States: IDLE, WRITE.
- req_ready = reset & (state == IDLE).
- IDLE, load:
  - mem_readEnable = 1 combinationally at T.
  - The selected lane is extracted from mem_readData, extended, and registered into resp_rdata.
- IDLE, word store: mem_writeEnable = 1 at T with mem_writeData = req_wdata.
- IDLE, byte/half store:
  - mem_readEnable = 1 at T.
  - mem_readData, the lane, size and wdata are registered.
  - Next state is WRITE.
- WRITE:
  - mem_writeEnable = 1 with the merged word; only the addressed bytes are replaced.
  - Next state is IDLE.
- All mem_* enables are 0 when not accepting and not in WRITE, and always 0 while reset is low.
- Load lane rules:
  - byte → bits [8*lane+7 : 8*lane]
  - half → bits [16*lane[1]+15 : 16*lane[1]]
  - Sign source is the lane MSB unless req_unsigned.

## Timing
- Load: accepted at T, resp_valid and resp_rdata at T+1.
- Word store: written at the T→T+1 edge, resp_valid at T+1.
- Sub-word store:
  - Read at T, WRITE state at T+1, BSRAM updated at the T+1→T+2 edge.
  - resp_valid at T+2.
  - req_ready is low at T+1 and high at T+2.
- A load to the same word accepted at T+2 returns the merged data; no forwarding is needed.
- Throughput: one request per cycle, except sub-word stores at one per two cycles.
- Reset (reset low at an edge):
  - state becomes IDLE; resp_valid, resp_rdata and resp_misaligned become 0.
  - A pending WRITE is dropped and the BSRAM is untouched.
  - req_ready is 0 while reset is low.
- req_valid while req_ready is low is ignored. Upstream must hold the request.

## Configuration
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A request is rejected when any of these holds: half with req_address[0]=1; word with req_address[1:0]≠0; size 11.
  - A rejected request causes no BSRAM access.
  - resp_valid and resp_misaligned are both 1 at T+1, with resp_rdata = 0.
- Undefined:
  - resp_misaligned is tied 0.
  - Half ignores address bit 0; word ignores bits [1:0]; size 11 is treated as word.

## Test plan
- Reset low for 2 cycles, then high → req_ready=0, all mem enables 0 and resp_valid=0 during reset; req_ready=1 on the first cycle after release.
- Word store 0xDEADBEEF to byte address 0x10, then word load from 0x10 → resp_rdata=0xDEADBEEF at T+1, one cycle per request.
- Byte store 0x80 to address 0x11, then signed byte load from 0x11 and word load from 0x10:
  - Byte load → 0xFFFFFF80.
  - Word load → 0xDEAD80EF.
  - req_ready low for exactly one cycle after the store.
- Unsigned half load from 0x12 after storing 0xDEADBEEF at 0x10 → 0x0000DEAD. Signed half load from 0x12 → 0xFFFFDEAD.
- Sub-word store at 0x14 with reset asserted in its WRITE cycle → word at 0x14 unchanged on a later load, state IDLE, no resp_valid.
- With DMEM_MISALIGN_TRAP_EN defined, word store to 0x13 → resp_misaligned=1 at T+1, mem_writeEnable never asserted. Without the macro, the same store writes word address 0x4.
